// File: rtl/cfo_corr_sched.sv
// Carrier-frequency-offset update scheduler. It applies new phase increments to the
// corrector only between packets, and holds run_rx low for a fixed flush window.
module cfo_corr_sched #(
    parameter int PHASE_WIDTH  = 24,
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 4,
    parameter int TIMEOUT      = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   cfg_tvalid,
    output logic                   cfg_tready,
    input  logic [PHASE_WIDTH-1:0] cfg_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic                   run_rx,
    output logic [PHASE_WIDTH-1:0] phase_cfo,
    output logic                   busy,
    output logic                   timeout_flag,
    output logic [15:0]            update_count
);

    // state    | meaning
    // IDLE     | stopped; cfg writes go straight to phase_cfo
    // RUN      | streaming; cfg write is captured as pending
    // WAIT_EOP | streaming; pending update waits for end of packet or timeout
    // FLUSH    | corrector halted while the new phase settles
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT_EOP, ST_FLUSH} state_t;

    localparam logic [7:0]  FLUSH_INIT = 8'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

    state_t                 r_state, w_state_nxt;
    logic [PHASE_WIDTH-1:0] r_pending, w_pending_nxt;
    logic [PHASE_WIDTH-1:0] r_phase, w_phase_nxt;
    logic [7:0]             r_flush_cnt, w_flush_cnt_nxt;
    logic [15:0]            r_to_cnt, w_to_cnt_nxt;
    logic [15:0]            r_upd_cnt, w_upd_cnt_nxt;
    logic                   r_in_pkt, w_in_pkt_nxt;
    logic                   r_timeout, w_timeout_nxt;

    logic w_pass, w_beat, w_eop, w_cfg_hs, w_body_beat;

    assign w_pass      = (r_state == ST_RUN) || (r_state == ST_WAIT_EOP);
    assign m_tvalid    = s_tvalid & w_pass;
    assign s_tready    = m_tready & w_pass;
    assign m_tdata     = s_tdata;
    assign m_tlast     = s_tlast;
    assign w_beat      = s_tvalid & s_tready;
    assign w_eop       = w_beat & s_tlast;
    assign w_body_beat = w_beat & ~s_tlast;

    assign cfg_tready   = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_cfg_hs     = cfg_tvalid & cfg_tready;
    assign run_rx       = w_pass;
    assign busy         = (r_state == ST_WAIT_EOP) || (r_state == ST_FLUSH);
    assign phase_cfo    = r_phase;
    assign timeout_flag = r_timeout;
    assign update_count = r_upd_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_phase     <= '0;
            r_flush_cnt <= '0;
            r_to_cnt    <= '0;
            r_upd_cnt   <= '0;
            r_in_pkt    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_phase     <= w_phase_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_upd_cnt   <= w_upd_cnt_nxt;
            r_in_pkt    <= w_in_pkt_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pending_nxt   = r_pending;
        w_phase_nxt     = r_phase;
        w_flush_cnt_nxt = r_flush_cnt;
        w_to_cnt_nxt    = r_to_cnt;
        w_upd_cnt_nxt   = r_upd_cnt;
        w_in_pkt_nxt    = r_in_pkt;
        w_timeout_nxt   = r_timeout;

        if (w_eop)
            w_in_pkt_nxt = 1'b0;
        else if (w_beat)
            w_in_pkt_nxt = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_cfg_hs)
                    w_phase_nxt = cfg_tdata;
                if (enable) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = FLUSH_INIT;
                end
            end
            ST_RUN: begin
                if (w_cfg_hs) begin
                    w_pending_nxt = cfg_tdata;
                    // Already between packets: apply the fresh value on this same edge.
                    if (w_eop || (!r_in_pkt && !w_beat)) begin
                        w_state_nxt     = ST_FLUSH;
                        w_flush_cnt_nxt = FLUSH_INIT;
                        w_phase_nxt     = cfg_tdata;
                        w_upd_cnt_nxt   = r_upd_cnt + 16'd1;
                    end else begin
                        w_state_nxt  = ST_WAIT_EOP;
                        w_to_cnt_nxt = '0;
                    end
                end else if (!enable && (w_eop || (!r_in_pkt && !w_body_beat))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_EOP: begin
                w_to_cnt_nxt = r_to_cnt + 16'd1;
                if (w_eop || (r_to_cnt == TO_LAST)) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = FLUSH_INIT;
                    w_phase_nxt     = r_pending;
                    w_upd_cnt_nxt   = r_upd_cnt + 16'd1;
                    if (!w_eop) begin
                        w_timeout_nxt = 1'b1;
                        w_in_pkt_nxt  = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == 8'd0)
                    w_state_nxt = enable ? ST_RUN : ST_IDLE;
                else
                    w_flush_cnt_nxt = r_flush_cnt - 8'd1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
